// File: rtl/pipe4_pkg.sv
// pipe4 shared definitions
// ALU function encodings and widths
package pipe4_pkg;

  localparam int FUNC_W = 3;

  localparam logic [FUNC_W-1:0] FN_ADD  = 3'd0;
  localparam logic [FUNC_W-1:0] FN_SUB  = 3'd1;
  localparam logic [FUNC_W-1:0] FN_AND  = 3'd2;
  localparam logic [FUNC_W-1:0] FN_XOR  = 3'd3;
  localparam logic [FUNC_W-1:0] FN_OR   = 3'd4;
  localparam logic [FUNC_W-1:0] FN_SLL  = 3'd5;
  localparam logic [FUNC_W-1:0] FN_SRL  = 3'd6;
  localparam logic [FUNC_W-1:0] FN_PASS = 3'd7;

endpackage

// File: rtl/pipe4_alu.sv
// pipe4 execute unit
// Combinational ALU with carry/borrow output
module pipe4_alu
  import pipe4_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [FUNC_W-1:0] i_func,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [SH_W-1:0] w_sh;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  assign w_sh   = i_b[SH_W-1:0];

  // Select the operation; carry only meaningful for add/sub
  always_comb begin
    o_result = i_a;
    o_carry  = 1'b0;
    unique case (i_func)
      FN_ADD: begin
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
      end
      FN_SUB: begin
        o_result = w_diff[DATA_W-1:0];
        o_carry  = w_diff[DATA_W];
      end
      FN_AND:  o_result = i_a & i_b;
      FN_XOR:  o_result = i_a ^ i_b;
      FN_OR:   o_result = i_a | i_b;
      FN_SLL:  o_result = i_a << w_sh;
      FN_SRL:  o_result = i_a >> w_sh;
      FN_PASS: o_result = i_a;
      default: o_result = i_a;
    endcase
  end

endmodule

// File: rtl/pipe4_gen.sv
// pipe4 datapath core
// Fetch/forward, execute, writeback, store
module pipe4_gen
  import pipe4_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rd,
  input  logic [FUNC_W-1:0] func,
  input  logic [MEM_AW-1:0] addr,
  output logic [DATA_W-1:0] z,
  output logic              z_valid,
  output logic              flag_zero,
  output logic              flag_carry,
  input  logic [MEM_AW-1:0] mem_raddr,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              dbg_we,
  input  logic [REG_AW-1:0] dbg_waddr,
  input  logic [DATA_W-1:0] dbg_wdata
);

  localparam int NREG = 2 ** REG_AW;
  localparam int NMEM = 2 ** MEM_AW;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_mem  [NMEM];

  logic              r_v12;
  logic [DATA_W-1:0] r_a12;
  logic [DATA_W-1:0] r_b12;
  logic [REG_AW-1:0] r_rd12;
  logic [FUNC_W-1:0] r_fn12;
  logic [MEM_AW-1:0] r_addr12;

  logic              r_v23;
  logic [DATA_W-1:0] r_res23;
  logic              r_c23;
  logic [REG_AW-1:0] r_rd23;
  logic [MEM_AW-1:0] r_addr23;

  logic [DATA_W-1:0] r_z;
  logic              r_zv;
  logic              r_zero;
  logic              r_carry;
  logic [MEM_AW-1:0] r_addr34;
  logic [DATA_W-1:0] r_rdata;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_fwd_a;
  logic [DATA_W-1:0] w_fwd_b;

  pipe4_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_a     (r_a12),
    .i_b     (r_b12),
    .i_func  (r_fn12),
    .o_result(w_alu_res),
    .o_carry (w_alu_c)
  );

  // Operand select: youngest in-flight producer wins
  always_comb begin
    w_fwd_a = r_regs[rs1];
    w_fwd_b = r_regs[rs2];
    if (r_v23 && r_rd23 == rs1) w_fwd_a = r_res23;
    if (r_v23 && r_rd23 == rs2) w_fwd_b = r_res23;
    if (r_v12 && r_rd12 == rs1) w_fwd_a = w_alu_res;
    if (r_v12 && r_rd12 == rs2) w_fwd_b = w_alu_res;
  end

  // S1/S2: operand capture then ALU result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v12    <= 1'b0;
      r_a12    <= '0;
      r_b12    <= '0;
      r_rd12   <= '0;
      r_fn12   <= '0;
      r_addr12 <= '0;
      r_v23    <= 1'b0;
      r_res23  <= '0;
      r_c23    <= 1'b0;
      r_rd23   <= '0;
      r_addr23 <= '0;
    end else begin
      r_v12    <= in_valid;
      r_a12    <= w_fwd_a;
      r_b12    <= w_fwd_b;
      r_rd12   <= rd;
      r_fn12   <= func;
      r_addr12 <= addr;
      r_v23    <= r_v12;
      r_res23  <= w_alu_res;
      r_c23    <= w_alu_c;
      r_rd23   <= r_rd12;
      r_addr23 <= r_addr12;
    end
  end

  // S3: result register with flags qualified by validity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z      <= '0;
      r_zv     <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_addr34 <= '0;
    end else begin
      r_z      <= r_res23;
      r_zv     <= r_v23;
      r_zero   <= r_v23 && (r_res23 == '0);
      r_carry  <= r_v23 && r_c23;
      r_addr34 <= r_addr23;
    end
  end

  // S3 writeback; pipeline write overrides a preload to the same reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (dbg_we) r_regs[dbg_waddr] <= dbg_wdata;
      if (r_v23) r_regs[r_rd23] <= r_res23;
    end
  end

  // S4: store; contents are not reset
  always_ff @(posedge clk) begin
    if (r_zv) r_mem[r_addr34] <= r_z;
  end

  // Registered read-back, old data on same-edge write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else        r_rdata <= r_mem[mem_raddr];
  end

  assign z          = r_z;
  assign z_valid    = r_zv;
  assign flag_zero  = r_zero;
  assign flag_carry = r_carry;
  assign mem_rdata  = r_rdata;

endmodule

// File: tb/tb_pipe4_gen.sv
// pipe4_gen testbench
// Scoreboarded scenarios against a sequential model
module tb_pipe4_gen;
  import pipe4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [2:0]  func = '0;
  logic [7:0]  addr = '0;
  logic [15:0] z;
  logic        z_valid, flag_zero, flag_carry;
  logic [7:0]  mem_raddr = 8'hFF;
  logic [15:0] mem_rdata;
  logic        dbg_we = 1'b0;
  logic [3:0]  dbg_waddr = '0;
  logic [15:0] dbg_wdata = '0;

  pipe4_gen #(.DATA_W(16), .REG_AW(4), .MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .z(z), .z_valid(z_valid), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .dbg_we(dbg_we),
    .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] z;
    logic        zf;
    logic        cf;
  } res_t;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_regs [16];
  logic [15:0] m_mem [256];
  res_t q_exp[$];
  res_t q_act[$];
  res_t m_t;

  always @(negedge clk) begin
    if (rst_n && z_valid) begin
      m_t.z = z;
      m_t.zf = flag_zero;
      m_t.cf = flag_carry;
      q_act.push_back(m_t);
    end
  end

  function automatic logic [16:0] model(input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [2:0] fn);
    logic [16:0] r;
    case (fn)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {(a < b), a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a ^ b};
      3'd4: r = {1'b0, a | b};
      3'd5: r = {1'b0, a << b[3:0]};
      3'd6: r = {1'b0, a >> b[3:0]};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  task automatic issue(input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] d, input logic [2:0] fn,
                       input logic [7:0] ad);
    logic [16:0] r;
    res_t e;
    r = model(m_regs[s1], m_regs[s2], fn);
    e.z = r[15:0];
    e.zf = (r[15:0] == 16'h0);
    e.cf = r[16];
    q_exp.push_back(e);
    m_regs[d] = r[15:0];
    m_mem[ad] = r[15:0];
    in_valid = 1'b1;
    rs1 = s1; rs2 = s2; rd = d; func = fn; addr = ad;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    rs1 = 4'($urandom); rs2 = 4'($urandom); rd = 4'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (4) bubble();
  endtask

  task automatic preload(input logic [3:0] r, input logic [15:0] v);
    dbg_we = 1'b1; dbg_waddr = r; dbg_wdata = v;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    m_regs[r] = v;
  endtask

  task automatic test_reset();
    res_t e, a;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (z !== 16'h0 || z_valid !== 1'b0 || flag_zero !== 1'b0 ||
        flag_carry !== 1'b0 || mem_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs got z=%h v=%b zf=%b cf=%b rd=%h need all 0",
               z, z_valid, flag_zero, flag_carry, mem_rdata);
    end
    rst_n = 1'b1;
    bubble();
    issue(4'd0, 4'd0, 4'd1, FN_ADD, 8'h00);
    checks++;
    if (z_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_k got z_valid=%b need 0", z_valid);
    end
    bubble();
    checks++;
    if (z_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_k1 got z_valid=%b need 0", z_valid);
    end
    bubble();
    checks++;
    if (z_valid !== 1'b1 || z !== 16'h0 || flag_zero !== 1'b1) begin
      failures++;
      $display("FAIL lat_k2 got v=%b z=%h zf=%b need 1 0000 1",
               z_valid, z, flag_zero);
    end
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL reset_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL reset_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
  endtask

  task automatic test_sub();
    res_t e, a;
    preload(4'd9, 16'd5);
    preload(4'd10, 16'd3);
    issue(4'd9, 4'd0, 4'd2, FN_PASS, 8'h01);
    issue(4'd10, 4'd0, 4'd3, FN_PASS, 8'h02);
    issue(4'd2, 4'd3, 4'd4, FN_SUB, 8'h03);
    issue(4'd3, 4'd2, 4'd5, FN_SUB, 8'h04);
    issue(4'd9, 4'd9, 4'hF, FN_AND, 8'h05);
    issue(4'd9, 4'd10, 4'hE, FN_OR, 8'h06);
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL sub_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL sub_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
  endtask

  task automatic test_forward();
    res_t e, a;
    issue(4'd2, 4'd3, 4'd1, FN_ADD, 8'h07);
    issue(4'd1, 4'd1, 4'd6, FN_ADD, 8'h08);
    issue(4'd2, 4'd3, 4'd1, FN_ADD, 8'h09);
    bubble();
    issue(4'd1, 4'd1, 4'd6, FN_ADD, 8'h0A);
    issue(4'd6, 4'd1, 4'd7, FN_SUB, 8'h0B);
    issue(4'd6, 4'd7, 4'd7, FN_ADD, 8'h0C);
    bubble();
    bubble();
    issue(4'd7, 4'd7, 4'd8, FN_ADD, 8'h0D);
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL fwd_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL fwd_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
  endtask

  task automatic test_shift_logic();
    res_t e, a;
    preload(4'd11, 16'h8001);
    preload(4'd12, 16'h0001);
    issue(4'd11, 4'd12, 4'd13, FN_SLL, 8'h20);
    issue(4'd11, 4'd12, 4'd14, FN_SRL, 8'h21);
    issue(4'd11, 4'd11, 4'd15, FN_XOR, 8'h22);
    issue(4'd11, 4'd11, 4'd0, FN_ADD, 8'h23);
    issue(4'd13, 4'd14, 4'd0, FN_OR, 8'h24);
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL shl_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL shl_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
  endtask

  task automatic test_mem();
    logic [15:0] old_v, new_v;
    mem_raddr = 8'hFF;
    issue(4'd11, 4'd0, 4'd7, FN_PASS, 8'hFF);
    drain();
    checks++;
    if (mem_rdata !== m_mem[8'hFF]) begin
      failures++;
      $display("FAIL mem_first got %h need %h", mem_rdata, m_mem[8'hFF]);
    end
    old_v = m_mem[8'hFF];
    issue(4'd12, 4'd0, 4'd7, FN_PASS, 8'hFF);
    new_v = m_mem[8'hFF];
    bubble();
    bubble();
    bubble();
    checks++;
    if (mem_rdata !== old_v) begin
      failures++;
      $display("FAIL mem_same_edge got %h need %h", mem_rdata, old_v);
    end
    bubble();
    checks++;
    if (mem_rdata !== new_v) begin
      failures++;
      $display("FAIL mem_k4 got %h need %h", mem_rdata, new_v);
    end
    q_exp.delete();
    q_act.delete();
  endtask

  task automatic test_reset_midstream();
    res_t e, a;
    logic [15:0] sv [3];
    issue(4'd9, 4'd0, 4'd7, FN_PASS, 8'h10);
    issue(4'd10, 4'd0, 4'd7, FN_PASS, 8'h11);
    issue(4'd11, 4'd0, 4'd7, FN_PASS, 8'h12);
    drain();
    for (int i = 0; i < 3; i++) sv[i] = m_mem[8'h10 + i];
    q_exp.delete();
    q_act.delete();
    issue(4'd9, 4'd10, 4'd13, FN_ADD, 8'h10);
    issue(4'd11, 4'd12, 4'd14, FN_SLL, 8'h11);
    issue(4'd10, 4'd9, 4'd15, FN_SUB, 8'h12);
    checks++;
    if (z_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre got z_valid=%b need 1", z_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (z !== 16'h0 || z_valid !== 1'b0 || flag_zero !== 1'b0 ||
        flag_carry !== 1'b0 || mem_rdata !== 16'h0) begin
      failures++;
      $display("FAIL mid_outputs got z=%h v=%b zf=%b cf=%b rd=%h need all 0",
               z, z_valid, flag_zero, flag_carry, mem_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    for (int i = 0; i < 3; i++) m_mem[8'h10 + i] = sv[i];
    q_exp.delete();
    q_act.delete();
    for (int i = 0; i < 3; i++) begin
      mem_raddr = 8'(8'h10 + i);
      bubble();
      checks++;
      if (mem_rdata !== sv[i]) begin
        failures++;
        $display("FAIL mid_mem%0d got %h need %h", i, mem_rdata, sv[i]);
      end
    end
    preload(4'd9, 16'h1234);
    issue(4'd9, 4'd9, 4'd1, FN_ADD, 8'h13);
    issue(4'd1, 4'd13, 4'd2, FN_ADD, 8'h14);
    issue(4'd13, 4'd0, 4'd3, FN_PASS, 8'h10);
    issue(4'd14, 4'd15, 4'd4, FN_OR, 8'h15);
    mem_raddr = 8'h10;
    drain();
    checks++;
    if (mem_rdata !== m_mem[8'h10]) begin
      failures++;
      $display("FAIL mid_resume_mem got %h need %h", mem_rdata, m_mem[8'h10]);
    end
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL mid_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL mid_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e, a;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'($urandom));
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(3) == 0) bubble();
      else issue(4'($urandom), 4'($urandom), 4'($urandom),
                 3'($urandom), 8'($urandom));
    end
    drain();
    while (q_exp.size() > 0) begin
      e = q_exp.pop_front();
      checks++;
      if (q_act.size() == 0) begin
        failures++;
        $display("FAIL b2b_sb missing result need z=%h", e.z);
      end else begin
        a = q_act.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL b2b_sb got %h/%b/%b need %h/%b/%b",
                   a.z, a.zf, a.cf, e.z, e.zf, e.cf);
        end
      end
    end
    checks++;
    if (q_act.size() != 0) begin
      failures++;
      $display("FAIL b2b_extra got %0d extra results need 0", q_act.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
    test_reset();
    test_sub();
    test_forward();
    test_shift_logic();
    test_mem();
    test_reset_midstream();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1);
  end

endmodule
